uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, FIFO entries; power of two, 4..256.
REQ-002 SHALL provide parameter AW, default 4, pointer width, equal to log2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port push  input  1  write-request strobe from the host, one byte per cycle while high.
REQ-006 SHALL have port push_data  input  8  byte to enqueue.
REQ-007 SHALL have port full  output  1  high when count equals DEPTH.
REQ-008 SHALL have port empty  output  1  high when count equals 0.
REQ-009 SHALL have port count  output  AW+1  number of bytes stored.
REQ-010 SHALL have port tx_busy  input  1  busy from the downstream UART transmitter.
REQ-011 SHALL have port tx_wr  output  1  single-cycle write strobe to the transmitter.
REQ-012 SHALL have port tx_data  output  8  byte presented with tx_wr, held stable until the next tx_wr.
REQ-013 SHALL have port overflow  output  1  sticky dropped-byte flag.
REQ-014 SHALL have port ovf_clr  input  1  clears overflow.

Function
REQ-015 SHALL store push_data at the write pointer when push=1 and full=0, then advance the write pointer modulo DEPTH.
REQ-016 SHALL discard push_data when push=1 and full=1; storage, pointers and count remain unchanged.
REQ-017 SHALL implement a drain FSM with states IDLE, ISSUE, WAIT_HI and WAIT_LO.
REQ-018 IDLE->ISSUE when empty=0 and tx_busy=0; the head byte is popped into the tx_data register on the same edge.
REQ-019 ISSUE: tx_wr=1 for exactly one cycle; next state is WAIT_HI.
REQ-020 WAIT_HI: next state is WAIT_LO once tx_busy=1; otherwise stay in WAIT_HI for at most 3 cycles, then go to IDLE.
REQ-021 WAIT_LO: next state is IDLE once tx_busy=0.
REQ-022 SHALL never assert tx_wr in any state other than ISSUE, and never while tx_busy=1 was sampled in IDLE.
REQ-023 A simultaneous push and pop on the same edge SHALL leave count unchanged; a push when full and a pop on the same edge SHALL still be rejected, since full is evaluated before the edge.
REQ-024 Minimum latency from push into an empty FIFO with tx_busy=0 to tx_wr=1 SHALL be 2 cycles: the write edge, then the pop edge, then tx_wr is visible.
REQ-025 Pointers SHALL be AW bits wide and wrap from DEPTH-1 to 0; count SHALL be maintained as an explicit up/down counter.
REQ-026 Bytes SHALL leave in strict FIFO order with no duplication or loss, except for rejected pushes.

Reset
REQ-027 reset=0 SHALL asynchronously force: state=IDLE, pointers=0, count=0, empty=1, full=0, tx_wr=0, tx_data=8'h00, overflow=0.
REQ-028 Reset asserted mid-transfer SHALL discard all queued bytes; the transmitter's in-flight frame is not the FIFO's concern.
REQ-029 Storage array contents SHALL not require reset.
REQ-030 Reset deassertion SHALL take effect at the next clk edge; no tx_wr SHALL be issued within 1 cycle after release.

Configuration
REQ-031 Macro UART_TXFIFO_OVF_EN defined: overflow SHALL set on any rejected push and clear on ovf_clr=1; if both occur in the same cycle, set wins.
REQ-032 Macro UART_TXFIFO_OVF_EN undefined: overflow SHALL be tied to 0, ovf_clr SHALL be ignored, and rejected pushes SHALL still be dropped silently.

Verification
REQ-033 Push 8'hA5 into an empty FIFO, tx_busy=0 -> tx_wr pulses 1 cycle at cycle+2 with tx_data=8'hA5; empty returns to 1.
REQ-034 Push 8'h01..8'h03 back-to-back, model tx_busy high 10 cycles after each tx_wr -> exactly 3 tx_wr pulses in order 01, 02, 03, each issued only after tx_busy falls.
REQ-035 With tx_busy held 1, push 17 bytes at DEPTH=16 -> full=1 after 16 pushes, count=16, the 17th byte is dropped, and overflow=1 (macro on) or 0 (macro off).
REQ-036 At count=16, push and busy release occur in the same cycle -> the push is rejected, one pop happens, and count=15.
REQ-037 Assert reset low with 5 bytes queued during WAIT_LO -> count=0, empty=1, and no tx_wr issues after release.
REQ-038 Tx_busy never rises after tx_wr -> the FSM returns to IDLE after 3 cycles and the next byte issues.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_fifo                                                    |
// | Purpose  : Byte FIFO that feeds a UART transmitter through a drain FSM.    |
// |            Define UART_TXFIFO_OVF_EN to enable the sticky overflow flag.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  input  logic          tx_busy,
  output logic          tx_wr,
  output logic [7:0]    tx_data,
  output logic          overflow,
  input  logic          ovf_clr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  localparam logic [AW:0] c_depth   = (AW+1)'(DEPTH);
  localparam logic [1:0]  c_hi_last = 2'd2;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [1:0]    r_hi_cnt;
  logic [7:0]    r_tx_data;
  logic          w_full;
  logic          w_empty;
  logic          w_push_ok;
  logic          w_pop;

  assign w_full    = (r_count == c_depth);
  assign w_empty   = (r_count == '0);
  assign w_push_ok = push & ~w_full;

  assign full    = w_full;
  assign empty   = w_empty;
  assign count   = r_count;
  assign tx_data = r_tx_data;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    tx_wr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !tx_busy) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tx_wr       = 1'b1;
        w_state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        // Give the transmitter three cycles to acknowledge before moving on.
        if (tx_busy)
          w_state_nxt = S_WAIT_LO;
        else if (r_hi_cnt == c_hi_last)
          w_state_nxt = S_IDLE;
      end
      S_WAIT_LO: begin
        if (!tx_busy)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_hi_cnt  <= 2'd0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_tx_data <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_hi_cnt <= (r_state == S_WAIT_HI) ? r_hi_cnt + 2'd1 : 2'd0;
      if (w_push_ok)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_tx_data <= r_mem[r_rd_ptr];
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage holds no control state, so it is left out of the reset domain.
  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wr_ptr] <= push_data;
  end

`ifdef UART_TXFIFO_OVF_EN
  logic r_overflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_overflow <= 1'b0;
    else if (push && w_full)
      r_overflow <= 1'b1;
    else if (ovf_clr)
      r_overflow <= 1'b0;
  end

  assign overflow = r_overflow;
`else
  logic w_unused_ovf_clr;

  assign w_unused_ovf_clr = ovf_clr;
  assign overflow         = 1'b0;
`endif

endmodule
`default_nettype wire
